// File: rtl/scope_capture_if.sv
// Bus bundle between the oscilloscope capture block and its environment:
// sample stream and trigger controls in, RAM write port and buffer handshake out.
interface scope_capture_if #(
  parameter int SAMPLE_W   = 16,
  parameter int DISP_W     = 8,
  parameter int DEPTH_LOG2 = 8
);
  logic                  new_sample_ready;
  logic [SAMPLE_W-1:0]   new_sample_in;
  logic [SAMPLE_W-1:0]   trig_level;
  logic                  trig_falling;
  logic                  auto_en;
  logic [3:0]            decim;
  logic                  wave_display_idle;
  logic [DEPTH_LOG2:0]   write_address;
  logic                  write_enable;
  logic [DISP_W-1:0]     write_sample;
  logic                  read_index;
  logic                  capture_done;

  // Capture block side: drives the RAM write port and buffer select.
  modport master (
    input  new_sample_ready, new_sample_in, trig_level, trig_falling,
           auto_en, decim, wave_display_idle,
    output write_address, write_enable, write_sample, read_index, capture_done
  );

  // Environment side: sample source, trigger controls and display.
  modport slave (
    output new_sample_ready, new_sample_in, trig_level, trig_falling,
           auto_en, decim, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index, capture_done
  );
endinterface

// File: rtl/scope_capture.sv
// Triggered, decimated oscilloscope capture into a ping-pong display RAM.
// Captures always fill buffer ~read_index; the display owns read_index.
module scope_capture #(
  parameter int SAMPLE_W     = 16,
  parameter int DISP_W       = 8,
  parameter int DEPTH_LOG2   = 8,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  scope_capture_if.master  bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int AUTO_W = ($clog2(AUTO_TIMEOUT + 1) > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ARMED,
    ACTIVE,
    WAIT
  } state_t;

  state_t                      state, state_next;
  logic signed [SAMPLE_W-1:0]  prev_sample;
  logic                        prev_valid;
  logic [AUTO_W-1:0]           auto_cnt;
  logic [3:0]                  decim_lat;
  logic [3:0]                  dec_cnt;
  logic [DEPTH_LOG2-1:0]       count;
  logic [DEPTH_LOG2:0]         wr_addr;
  logic                        wr_en;
  logic [DISP_W-1:0]           wr_sample;
  logic                        read_idx;
  logic                        done_r;

  logic signed [SAMPLE_W-1:0]  sample_s;
  logic signed [SAMPLE_W-1:0]  level_s;
  logic [DISP_W-1:0]           disp_raw;
  logic [DISP_W-1:0]           disp_sample;
  logic                        edge_hit;
  logic                        auto_hit;
  logic                        trigger;
  logic                        accept;
  logic                        last_accept;
  logic                        release_buf;

  assign sample_s    = bus.new_sample_in;
  assign level_s     = bus.trig_level;
  assign disp_raw    = bus.new_sample_in[SAMPLE_W-1 -: DISP_W];
  // Signed to offset-binary: flip the top bit of the truncated sample.
  assign disp_sample = disp_raw ^ (DISP_W'(1) << (DISP_W - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARMED;
    else          state <= state_next;
  end

  // Trigger detection, accept decision and next-state logic.
  always_comb begin
    state_next  = state;
    trigger     = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    release_buf = 1'b0;
    if (bus.trig_falling)
      edge_hit = prev_valid && (prev_sample >= level_s) && (sample_s < level_s);
    else
      edge_hit = prev_valid && (prev_sample < level_s) && (sample_s >= level_s);
    auto_hit = bus.auto_en && (auto_cnt >= AUTO_W'(AUTO_TIMEOUT));
    unique case (state)
      ARMED: begin
        if (bus.new_sample_ready && (edge_hit || auto_hit)) begin
          trigger    = 1'b1;
          accept     = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.new_sample_ready && (dec_cnt == 4'd0)) begin
          accept = 1'b1;
          if (count == DEPTH_LOG2'(DEPTH - 1)) begin
            last_accept = 1'b1;
            state_next  = WAIT;
          end
        end
      end
      WAIT: begin
        // done_r marks the first WAIT cycle, in which the display is not polled.
        if (!done_r && bus.wave_display_idle) begin
          release_buf = 1'b1;
          state_next  = ARMED;
        end
      end
      default: state_next = ARMED;
    endcase
  end

  // Datapath: write port, counters, trigger history and buffer select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      auto_cnt    <= '0;
      decim_lat   <= '0;
      dec_cnt     <= '0;
      count       <= '0;
      wr_addr     <= '0;
      wr_en       <= 1'b0;
      wr_sample   <= '0;
      read_idx    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      wr_en  <= accept;
      done_r <= last_accept;
      if (accept) begin
        wr_addr   <= {~read_idx, count};
        wr_sample <= disp_sample;
        count     <= count + 1'b1;
        dec_cnt   <= trigger ? bus.decim : decim_lat;
      end else if (state == ACTIVE && bus.new_sample_ready) begin
        dec_cnt <= dec_cnt - 1'b1;
      end
      if (trigger)
        decim_lat <= bus.decim;
      if (state == ARMED && bus.new_sample_ready && !trigger) begin
        prev_sample <= sample_s;
        prev_valid  <= 1'b1;
        if (auto_cnt != AUTO_W'(AUTO_TIMEOUT))
          auto_cnt <= auto_cnt + 1'b1;
      end
      if (release_buf) begin
        read_idx   <= ~read_idx;
        prev_valid <= 1'b0;
        auto_cnt   <= '0;
      end
    end
  end

  assign bus.write_address = wr_addr;
  assign bus.write_enable  = wr_en;
  assign bus.write_sample  = wr_sample;
  assign bus.read_index    = read_idx;
  assign bus.capture_done  = done_r;
endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: expected RAM writes are queued as
// samples are driven and checked in order as write_enable pulses appear.
module tb_scope_capture;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  scope_capture_if #(.SAMPLE_W(16), .DISP_W(8), .DEPTH_LOG2(8)) bus ();

  scope_capture #(
    .SAMPLE_W(16), .DISP_W(8), .DEPTH_LOG2(8), .AUTO_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int          checks   = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  logic        exp_rd   = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] e_w;

  function automatic logic [7:0] disp(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  // Write monitor: pops the scoreboard on each write strobe.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.capture_done === 1'b1) done_cnt++;
      if (bus.write_enable === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr=%h sample=%h, required no write",
                   bus.write_address, bus.write_sample);
        end else begin
          e_w = exp_q.pop_front();
          if ({bus.write_address, bus.write_sample} !== e_w) begin
            fails++;
            $display("FAIL write_data: got addr=%h sample=%h, required addr=%h sample=%h",
                     bus.write_address, bus.write_sample, e_w[16:8], e_w[7:0]);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] s, input bit acc, input int idx);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    if (acc) exp_q.push_back({~exp_rd, 8'(idx), disp(s)});
    @(posedge clk); #1;
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic finish_capture(input int from);
    int base;
    base = done_cnt;
    for (int i = from; i < 256; i++) send(16'(i * 313 + 17), 1'b1, i);
    checks++;
    if (bus.capture_done !== 1'b1) begin
      fails++; $display("FAIL capture_done_pulse: got %b, required 1", bus.capture_done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.read_index !== exp_rd) begin
      fails++; $display("FAIL read_index_hold: got %b, required %b", bus.read_index, exp_rd);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL writes_drained: got %0d pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
    exp_rd = ~exp_rd;
    checks++;
    if (bus.read_index !== exp_rd) begin
      fails++; $display("FAIL read_index_toggle: got %b, required %b", bus.read_index, exp_rd);
    end
    checks++;
    if (done_cnt != base + 1) begin
      fails++; $display("FAIL capture_done_once: got %0d pulses, required 1", done_cnt - base);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.trig_level        = '0;
    bus.trig_falling      = 1'b0;
    bus.auto_en           = 1'b0;
    bus.decim             = 4'd0;
    bus.wave_display_idle = 1'b1;
    #2;
    checks++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL rst_we: got %b, required 0", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h000) begin fails++; $display("FAIL rst_addr: got %h, required 000", bus.write_address); end
    checks++; if (bus.write_sample !== 8'h00) begin fails++; $display("FAIL rst_sample: got %h, required 00", bus.write_sample); end
    checks++; if (bus.read_index !== 1'b0) begin fails++; $display("FAIL rst_read_index: got %b, required 0", bus.read_index); end
    checks++; if (bus.capture_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, required 0", bus.capture_done); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rising();
    send(16'hFB00, 1'b0, 0);
    send(16'hFF00, 1'b0, 0);
    send(16'h0300, 1'b1, 0);
    checks++; if (bus.write_enable !== 1'b1) begin fails++; $display("FAIL rise_we: got %b, required 1", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h100) begin fails++; $display("FAIL rise_addr: got %h, required 100", bus.write_address); end
    checks++; if (bus.write_sample !== 8'h83) begin fails++; $display("FAIL rise_sample: got %h, required 83", bus.write_sample); end
    finish_capture(1);
  endtask

  task automatic test_falling();
    bus.trig_falling = 1'b1;
    bus.trig_level   = 16'h1000;
    send(16'h0800, 1'b0, 0);
    send(16'h0400, 1'b0, 0);
    checks++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL fall_no_trig: got %b, required 0", bus.write_enable); end
    send(16'h2000, 1'b0, 0);
    send(16'h0800, 1'b1, 0);
    checks++; if (bus.write_sample !== 8'h88) begin fails++; $display("FAIL fall_sample: got %h, required 88", bus.write_sample); end
    checks++; if (bus.write_address !== 9'h000) begin fails++; $display("FAIL fall_addr: got %h, required 000", bus.write_address); end
    finish_capture(1);
    bus.trig_falling = 1'b0;
    bus.trig_level   = 16'h0000;
  endtask

  task automatic test_decim();
    bus.decim = 4'd2;
    send(16'hFF00, 1'b0, 0);
    send(16'h0100, 1'b1, 0);
    checks++; if (bus.write_enable !== 1'b1) begin fails++; $display("FAIL decim_first_we: got %b, required 1", bus.write_enable); end
    bus.decim = 4'd0;
    for (int i = 1; i < 256; i++) begin
      for (int k = 0; k < 2; k++) begin
        send(16'($urandom), 1'b0, 0);
        checks++;
        if (bus.write_enable !== 1'b0) begin
          fails++; $display("FAIL decim_skip_%0d: got we=%b, required 0", i, bus.write_enable);
        end
      end
      send(16'($urandom), 1'b1, i);
      checks++;
      if (bus.write_enable !== 1'b1) begin
        fails++; $display("FAIL decim_write_%0d: got we=%b, required 1", i, bus.write_enable);
      end
    end
    checks++; if (bus.write_address[7:0] !== 8'hFF) begin fails++; $display("FAIL decim_last_index: got %h, required ff", bus.write_address[7:0]); end
    finish_capture(256);
  endtask

  task automatic test_auto();
    bus.auto_en = 1'b1;
    for (int i = 0; i < 8; i++) send(16'h0000, 1'b0, 0);
    checks++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL auto_early: got %b, required 0", bus.write_enable); end
    send(16'h0000, 1'b1, 0);
    checks++; if (bus.write_enable !== 1'b1) begin fails++; $display("FAIL auto_fire: got %b, required 1", bus.write_enable); end
    finish_capture(1);
    bus.auto_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(16'h0000, 1'b0, 0);
      checks++;
      if (bus.write_enable !== 1'b0) begin
        fails++; $display("FAIL auto_off_%0d: got we=%b, required 0", i, bus.write_enable);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(16'hFF00, 1'b0, 0);
    send(16'h0100, 1'b1, 0);
    for (int i = 1; i <= 8'h40; i++) send(16'(i * 97), 1'b1, i);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    exp_rd = 1'b0;
    checks++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL mid_rst_we: got %b, required 0", bus.write_enable); end
    checks++; if (bus.read_index !== 1'b0) begin fails++; $display("FAIL mid_rst_read_index: got %b, required 0", bus.read_index); end
    checks++; if (bus.write_address !== 9'h000) begin fails++; $display("FAIL mid_rst_addr: got %h, required 000", bus.write_address); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_rst_drained: got %0d pending, required 0", exp_q.size()); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    send(16'hFF00, 1'b0, 0);
    send(16'h0100, 1'b1, 0);
    checks++; if (bus.write_address !== 9'h100) begin fails++; $display("FAIL restart_addr: got %h, required 100", bus.write_address); end
    @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL restart_drained: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_decim();
    test_auto();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
